ama_riscv_bp_spec: RTL and testbench



---
 rtl/ama_riscv_bp_spec_pkg.sv | 43 ++++
 rtl/ama_riscv_bp_ckpt_fifo.sv | 54 +++++
 rtl/ama_riscv_bp_spec.sv | 132 +++++++++++++
 tb/tb_ama_riscv_bp_spec.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_bp_spec_pkg.sv
// rtl/ama_riscv_bp_spec_pkg.sv - shared types and sizing helpers for the speculative branch predictor
// Index scheme enum, prediction type, checkpoint entry and table sizing functions.
package ama_riscv_bp_spec_pkg;

  typedef enum logic [1:0] {
    BP_BIMODAL = 2'd0,
    BP_GLOBAL  = 2'd1,
    BP_GSELECT = 2'd2,
    BP_GSHARE  = 2'd3
  } bp_t;

  typedef enum logic {
    BR_NT = 1'b0,
    BR_T  = 1'b1
  } branch_t;

  // Checkpoints carry the widest supported index; only the low IDX_BITS are meaningful.
  localparam int unsigned IDX_W_MAX = 16;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    branch_t              pred;
  } bp_ckpt_t;

  function automatic int unsigned bp_idx_bits(input bp_t sel, input int unsigned pc_bits,
                                              input int unsigned gr_bits);
    case (sel)
      BP_BIMODAL: return pc_bits;
      BP_GLOBAL:  return gr_bits;
      BP_GSELECT: return pc_bits + gr_bits;
      default:    return (pc_bits > gr_bits) ? pc_bits : gr_bits;
    endcase
  endfunction

  function automatic int unsigned bp_cnt_max(input int unsigned cnt_bits);
    return (1 << cnt_bits) - 1;
  endfunction

  function automatic int unsigned bp_thr(input int unsigned cnt_bits);
    return (cnt_bits == 1) ? 1 : (bp_cnt_max(cnt_bits) >> 1);
  endfunction

endpackage

// File: rtl/ama_riscv_bp_ckpt_fifo.sv
// rtl/ama_riscv_bp_ckpt_fifo.sv - in-order checkpoint FIFO for unresolved branches
// Holds {idx, pred} per in-flight branch; clear drops every entry in one cycle.
module ama_riscv_bp_ckpt_fifo
  import ama_riscv_bp_spec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  bp_ckpt_t                   push_data,
  input  logic                       pop,
  input  logic                       clear,
  output bp_ckpt_t                   head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  bp_ckpt_t          mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ama_riscv_bp_spec.sv
// rtl/ama_riscv_bp_spec.sv - multi-in-flight speculative branch predictor (stats under BP_STATS_EN)
// Predicts at decode, checkpoints {idx, pred}, trains in order at resolve, repairs sgr on kill.
module ama_riscv_bp_spec
  import ama_riscv_bp_spec_pkg::*;
#(
  parameter int unsigned PC_BITS     = 5,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned GR_BITS     = 5,
  parameter int unsigned DEPTH       = 4,
  parameter bp_t         BP_TYPE_SEL = BP_GSHARE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_pc,
  output branch_t                    pred,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic                       flush,
  output logic                       mispred,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic [31:0]                stat_res,
  output logic [31:0]                stat_mis
);

  localparam int unsigned IDX_BITS = bp_idx_bits(BP_TYPE_SEL, PC_BITS, GR_BITS);
  localparam int unsigned TBL      = 1 << IDX_BITS;
  localparam int unsigned CW       = $clog2(DEPTH+1);
  localparam logic [CNT_BITS-1:0] CNT_MAX_V = CNT_BITS'(bp_cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] THR_V     = CNT_BITS'(bp_thr(CNT_BITS));

  logic [CNT_BITS-1:0] cnt_q [TBL];
  logic [GR_BITS-1:0]  sgr_q, sgr_d, cgr_q, cgr_d;
  logic [PC_BITS-1:0]  pc_part;
  logic [IDX_BITS-1:0] req_idx, upd_idx;
  logic [CNT_BITS-1:0] cnt_cur, cnt_nxt;
  bp_ckpt_t            push_ckpt, head;
  logic                res_fire, kill, accept;
  logic                unused_bits;

  assign pc_part = req_pc[PC_BITS+1:2];

  generate
    if (BP_TYPE_SEL == BP_BIMODAL) begin : g_bimodal
      assign req_idx = pc_part;
    end else if (BP_TYPE_SEL == BP_GLOBAL) begin : g_global
      assign req_idx = sgr_q;
    end else if (BP_TYPE_SEL == BP_GSELECT) begin : g_gselect
      assign req_idx = {pc_part, sgr_q};
    end else begin : g_gshare
      localparam int unsigned SH = (PC_BITS > GR_BITS) ? (PC_BITS - GR_BITS) : 0;
      assign req_idx = IDX_BITS'(pc_part) ^ (IDX_BITS'(sgr_q) << SH);
    end
  endgenerate

  assign pred      = branch_t'(cnt_q[req_idx] >= THR_V);
  assign req_ready = (inflight != CW'(DEPTH));
  assign res_fire  = res_valid && (inflight != '0);
  assign mispred   = res_fire && (res_taken != logic'(head.pred));
  assign kill      = mispred || flush;
  assign accept    = req_valid && req_ready && !kill;

  always_comb begin
    push_ckpt                    = '0;
    push_ckpt.idx[IDX_BITS-1:0]  = req_idx;
    push_ckpt.pred               = pred;
  end

  ama_riscv_bp_ckpt_fifo #(.DEPTH(DEPTH)) u_ckpt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_ckpt),
    .pop       (res_fire),
    .clear     (kill),
    .head      (head),
    .count     (inflight)
  );

  assign upd_idx = head.idx[IDX_BITS-1:0];
  assign cnt_cur = cnt_q[upd_idx];

  always_comb begin
    cnt_nxt = cnt_cur;
    if (res_taken && (cnt_cur != CNT_MAX_V))  cnt_nxt = cnt_cur + 1'b1;
    else if (!res_taken && (cnt_cur != '0))  cnt_nxt = cnt_cur - 1'b1;
  end

  // A kill always rebuilds sgr from the post-resolve committed history.
  always_comb begin
    cgr_d = res_fire ? {cgr_q[GR_BITS-2:0], res_taken} : cgr_q;
    sgr_d = sgr_q;
    if (kill)        sgr_d = cgr_d;
    else if (accept) sgr_d = {sgr_q[GR_BITS-2:0], logic'(pred)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL; i++) cnt_q[i] <= THR_V;
      sgr_q <= '0;
      cgr_q <= '0;
    end else begin
      sgr_q <= sgr_d;
      cgr_q <= cgr_d;
      if (res_fire) cnt_q[upd_idx] <= cnt_nxt;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_res_q, stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (res_fire) stat_res_q <= stat_res_q + 32'd1;
      if (mispred)  stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_res = stat_res_q;
  assign stat_mis = stat_mis_q;
`else
  assign stat_res = '0;
  assign stat_mis = '0;
`endif

  assign unused_bits = ^{req_pc[31:PC_BITS+2], req_pc[1:0], head.idx[IDX_W_MAX-1:IDX_BITS]};

endmodule

// File: tb/tb_ama_riscv_bp_spec.sv
// tb/tb_ama_riscv_bp_spec.sv - directed self-checking bench for ama_riscv_bp_spec
// Default gshare config: idx = pc[6:2] ^ sgr, counters reset to 1 (predict taken).
module tb_ama_riscv_bp_spec;
  import ama_riscv_bp_spec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  branch_t     pred;
  logic        res_valid;
  logic        res_taken;
  logic        flush;
  logic        mispred;
  logic [2:0]  inflight;
  logic [31:0] stat_res;
  logic [31:0] stat_mis;

  int n_chk = 0;
  int n_err = 0;

  ama_riscv_bp_spec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .pred      (pred),
    .res_valid (res_valid),
    .res_taken (res_taken),
    .flush     (flush),
    .mispred   (mispred),
    .inflight  (inflight),
    .stat_res  (stat_res),
    .stat_mis  (stat_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic exp_mis);
    res_valid = 1'b1;
    res_taken = taken;
    #1;
    check_eq("resolve_mispred", 32'(mispred), 32'(exp_mis));
    step();
    res_valid = 1'b0;
  endtask

  logic [31:0] t4_pc [5];

  initial begin
    rst_n  = 1'b0;
    req_pc = '0;
    idle();
    t4_pc[0] = 32'd5 << 2;
    t4_pc[1] = 32'd4 << 2;
    t4_pc[2] = 32'd6 << 2;
    t4_pc[3] = 32'd2 << 2;
    t4_pc[4] = 32'd10 << 2;

    // reset state and first mispredict
    do_reset();
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mispred", 32'(mispred), 32'd0);
    check_eq("rst_sgr", 32'(dut.sgr_q), 32'd0);
    check_eq("rst_cgr", 32'(dut.cgr_q), 32'd0);
    check_eq("rst_stat_res", stat_res, 32'd0);
    check_eq("rst_stat_mis", stat_mis, 32'd0);
    res_valid = 1'b1;
    res_taken = 1'b0;
    #1;
    check_eq("empty_res_mispred", 32'(mispred), 32'd0);
    step();
    res_valid = 1'b0;
    check_eq("empty_res_cgr", 32'(dut.cgr_q), 32'd0);
    check_eq("empty_res_inflight", 32'(inflight), 32'd0);
    req_valid = 1'b1;
    req_pc    = 32'h40;
    #1;
    check_eq("pred_40_init", 32'(pred), 32'd1);
    step();
    req_valid = 1'b0;
    check_eq("t1_sgr_after_acc", 32'(dut.sgr_q), 32'd1);
    resolve(1'b0, 1'b1);
    check_eq("t1_cnt16", 32'(dut.cnt_q[16]), 32'd0);
    check_eq("t1_inflight", 32'(inflight), 32'd0);
    check_eq("t1_sgr", 32'(dut.sgr_q), 32'd0);
    req_pc = 32'h40;
    #1;
    check_eq("pred_40_after", 32'(pred), 32'd0);

    // fill to DEPTH, reject when full, concurrent accept+resolve
    do_reset();
    repeat (4) accept(32'h0);
    check_eq("full_inflight", 32'(inflight), 32'd4);
    check_eq("full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_pc    = 32'h0;
    step();
    req_valid = 1'b0;
    check_eq("full_drop_inflight", 32'(inflight), 32'd4);
    check_eq("full_drop_sgr", 32'(dut.sgr_q), 32'h0F);
    resolve(1'b1, 1'b0);
    check_eq("pop_inflight", 32'(inflight), 32'd3);
    check_eq("pop_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_pc    = 32'h0;
    res_valid = 1'b1;
    res_taken = 1'b1;
    #1;
    check_eq("both_mispred", 32'(mispred), 32'd0);
    step();
    idle();
    check_eq("both_inflight", 32'(inflight), 32'd3);
    check_eq("both_cgr", 32'(dut.cgr_q), 32'h03);
    check_eq("both_sgr", 32'(dut.sgr_q), 32'h1F);

    // mispredict repairs speculative history
    do_reset();
    repeat (3) accept(32'h0);
    check_eq("t3_sgr", 32'(dut.sgr_q), 32'h07);
    resolve(1'b0, 1'b1);
    check_eq("t3_inflight", 32'(inflight), 32'd0);
    check_eq("t3_sgr_rep", 32'(dut.sgr_q), 32'd0);
    check_eq("t3_cgr", 32'(dut.cgr_q), 32'd0);
    check_eq("t3_cnt0", 32'(dut.cnt_q[0]), 32'd0);

    // saturation on idx 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      accept(t4_pc[i]);
      resolve(1'b1, 1'b0);
    end
    check_eq("sat_cnt5", 32'(dut.cnt_q[5]), 32'd3);
    check_eq("sat_cgr", 32'(dut.cgr_q), 32'h1F);
    accept(32'd26 << 2);
    resolve(1'b0, 1'b1);
    check_eq("desat_cnt5", 32'(dut.cnt_q[5]), 32'd2);
    check_eq("desat_sgr", 32'(dut.sgr_q), 32'h1E);
    req_pc = 32'd27 << 2;
    #1;
    check_eq("desat_pred", 32'(pred), 32'd1);
`ifdef BP_STATS_EN
    check_eq("stat_res6", stat_res, 32'd6);
    check_eq("stat_mis1", stat_mis, 32'd1);
`else
    check_eq("stat_res_off", stat_res, 32'd0);
    check_eq("stat_mis_off", stat_mis, 32'd0);
`endif

    // flush alone, then flush with resolve
    do_reset();
    accept(32'h0);
    accept(32'h0);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'h0;
    step();
    idle();
    check_eq("flush_inflight", 32'(inflight), 32'd0);
    check_eq("flush_sgr", 32'(dut.sgr_q), 32'd0);
    check_eq("flush_cgr", 32'(dut.cgr_q), 32'd0);
    accept(32'h0);
    accept(32'h0);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'h0;
    res_valid = 1'b1;
    res_taken = 1'b1;
    #1;
    check_eq("flres_mispred", 32'(mispred), 32'd0);
    step();
    idle();
    check_eq("flres_inflight", 32'(inflight), 32'd0);
    check_eq("flres_sgr", 32'(dut.sgr_q), 32'd1);
    check_eq("flres_cgr", 32'(dut.cgr_q), 32'd1);
    check_eq("flres_cnt0", 32'(dut.cnt_q[0]), 32'd2);

    // asynchronous reset with branches in flight
    do_reset();
    accept(32'h0);
    resolve(1'b1, 1'b0);
    repeat (3) accept(32'h0);
    check_eq("pre_rst_inflight", 32'(inflight), 32'd3);
`ifdef BP_STATS_EN
    check_eq("pre_rst_stat_res", stat_res, 32'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_inflight", 32'(inflight), 32'd0);
    check_eq("arst_ready", 32'(req_ready), 32'd1);
    check_eq("arst_stat_res", stat_res, 32'd0);
    check_eq("arst_stat_mis", stat_mis, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
